// File: rtl/tx_arbiter_if.sv
// Requester and transmitter signals of tx_arbiter, bundled as one interface.
// master: requesters plus transmitter side; slave: the arbiter itself.
interface tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DATA_IN;
  logic [NREQ-1:0]       GRANT;
  logic [NREQ-1:0]       ACK;
  logic                  ERR;
  logic                  TX_START;
  logic [WIDTH-1:0]      TX_DATA;
  logic                  TX_BUSY;

  modport master (
    output REQ, DATA_IN, TX_BUSY,
    input  GRANT, ACK, ERR, TX_START, TX_DATA
  );

  modport slave (
    input  REQ, DATA_IN, TX_BUSY,
    output GRANT, ACK, ERR, TX_START, TX_DATA
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NREQ requesters.
// Define TX_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead.
module tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input logic         CLK,
  input logic         RST_N,
  tx_arbiter_if.slave bus
);
  localparam int         IDXW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
  localparam logic [7:0] GAP_LAST    = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t           state_q, state_nxt, frame_end;
  logic [7:0]       cnt_q, cnt_nxt, cnt_inc;
  logic [NREQ-1:0]  grant_q, grant_nxt;
  logic [NREQ-1:0]  ack_q, ack_nxt;
  logic             err_q, err_nxt;
  logic             tx_start_q, tx_start_nxt;
  logic [WIDTH-1:0] tx_data_q, tx_data_nxt;
  logic [IDXW-1:0]  winner;
  logic             any_req;

  assign any_req   = |bus.REQ;
  assign cnt_inc   = cnt_q + 8'd1;
  assign frame_end = (GAP_CYCLES == 0) ? IDLE : GAP;

`ifdef TX_ARBITER_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.REQ[i]) winner = IDXW'(i);
    end
  end
`else
  logic [IDXW-1:0] last_q;

  // Scan downward so the requester closest after last_q is written last and wins.
  always_comb begin
    winner = last_q;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.REQ[(int'(last_q) + k) % NREQ]) winner = IDXW'((int'(last_q) + k) % NREQ);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= IDXW'(NREQ - 1);
    end else if (state_q == IDLE && any_req) begin
      last_q <= winner;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      grant_q    <= grant_nxt;
      ack_q      <= ack_nxt;
      err_q      <= err_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
    end
  end

  // One counter serves both the busy-rise timeout and the inter-frame gap.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (bus.TX_BUSY) begin
          state_nxt = WAIT_DONE;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_nxt = frame_end;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          state_nxt = frame_end;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    grant_nxt    = grant_q;
    ack_nxt      = '0;
    err_nxt      = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          tx_data_nxt       = bus.DATA_IN[int'(winner) * WIDTH +: WIDTH];
        end
      end
      START: begin
        tx_start_nxt = 1'b1;
      end
      WAIT_BUSY: begin
        if (!bus.TX_BUSY && cnt_inc == TIMEOUT_LIM) begin
          ack_nxt   = grant_q;
          err_nxt   = 1'b1;
          grant_nxt = '0;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          ack_nxt   = grant_q;
          grant_nxt = '0;
        end
      end
      GAP: begin
      end
      default: begin
        grant_nxt   = '0;
        tx_data_nxt = '0;
      end
    endcase
  end

  assign bus.GRANT    = grant_q;
  assign bus.ACK      = ack_q;
  assign bus.ERR      = err_q;
  assign bus.TX_START = tx_start_q;
  assign bus.TX_DATA  = tx_data_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized bench for tx_arbiter; a transaction-level model predicts winner, word and timing.
// Cycle numbers are counted at falling edges, where outputs are sampled and inputs driven.
module tb_tx_arbiter;
  localparam int NREQ       = 4;
  localparam int WIDTH      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 15;
  localparam int DW         = NREQ * WIDTH;

  logic clk;
  logic rst_n;

  tx_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  tx_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;
  int ready_cyc   = 0;
  int rr_last     = NREQ - 1;
  logic [WIDTH-1:0] words [NREQ];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] mask);
`ifdef TX_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (mask[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (mask[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic randomWords();
    for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
  endtask

  // One full transaction: request, grant, start pulse, transmitter response, acknowledge.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input bit timeout_mode,
                               input int busy_delay, input int frame_len);
    int exp_winner, exp_grant_cyc, exp_ack_cyc, start_cyc, hold_errs;
    logic [WIDTH-1:0] exp_word;
    bit seen;
    for (int i = 0; i < NREQ; i++) bus.DATA_IN[i*WIDTH +: WIDTH] = words[i];
    bus.REQ       = mask;
    exp_winner    = pickWinner(mask);
    exp_word      = words[exp_winner];
    exp_grant_cyc = (cyc + 1 > ready_cyc) ? cyc + 1 : ready_cyc;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      nextCycle();
      if (bus.GRANT != '0) seen = 1'b1;
    end
    checkOutput("grantSeen", 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput("grantTime", cyc, exp_grant_cyc);
    checkOutput("grant", 32'(bus.GRANT), 32'd1 << exp_winner);
    rr_last = exp_winner;
    // Requests and words may change freely once the grant is taken.
    bus.REQ     = NREQ'($urandom);
    bus.DATA_IN = DW'($urandom);
    nextCycle();
    checkOutput("txStart", 32'(bus.TX_START), 32'd1);
    checkOutput("txData", 32'(bus.TX_DATA), 32'(exp_word));
    start_cyc   = cyc;
    exp_ack_cyc = timeout_mode ? start_cyc + TIMEOUT : start_cyc + busy_delay + frame_len + 1;
    hold_errs   = 0;
    seen        = 1'b0;
    for (int w = 0; w < TIMEOUT + busy_delay + frame_len + 10 && !seen; w++) begin
      if (!timeout_mode)
        bus.TX_BUSY = (cyc >= start_cyc + busy_delay) && (cyc < start_cyc + busy_delay + frame_len);
      nextCycle();
      if (bus.ACK != '0) seen = 1'b1;
      else if (bus.GRANT != NREQ'(1 << exp_winner) || bus.TX_START || bus.ERR || bus.TX_DATA != exp_word)
        hold_errs++;
    end
    bus.TX_BUSY = 1'b0;
    checkOutput("ackSeen", 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput("ackTime", cyc, exp_ack_cyc);
    checkOutput("ack", 32'(bus.ACK), 32'd1 << exp_winner);
    checkOutput("err", 32'(bus.ERR), 32'(timeout_mode));
    checkOutput("grantClr", 32'(bus.GRANT), 32'd0);
    checkOutput("holdStable", hold_errs, 32'd0);
    ready_cyc = cyc + GAP_CYCLES + 1;
    nextCycle();
    checkOutput("ackPulse", 32'({bus.ACK, bus.ERR}), 32'd0);
    checkOutput("txDataHeld", 32'(bus.TX_DATA), 32'(exp_word));
  endtask

  // Reset asserted mid-frame while the transmitter is still busy.
  task automatic applyResetMidFrame();
    bit seen;
    bus.REQ     = NREQ'(1);
    bus.DATA_IN = DW'($urandom);
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      nextCycle();
      if (bus.GRANT != '0) seen = 1'b1;
    end
    checkOutput("rstPreGrant", 32'(seen), 32'd1);
    nextCycle();
    bus.TX_BUSY = 1'b1;
    repeat (3) nextCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstGrant", 32'(bus.GRANT), 32'd0);
    checkOutput("rstAck", 32'(bus.ACK), 32'd0);
    checkOutput("rstStart", 32'(bus.TX_START), 32'd0);
    checkOutput("rstData", 32'(bus.TX_DATA), 32'd0);
    bus.TX_BUSY = 1'b0;
    nextCycle();
    rst_n     = 1'b1;
    rr_last   = NREQ - 1;
    ready_cyc = cyc + 1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.REQ     = '0;
    bus.DATA_IN = '0;
    bus.TX_BUSY = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("resetGrant", 32'(bus.GRANT), 32'd0);
    checkOutput("resetAck", 32'(bus.ACK), 32'd0);
    checkOutput("resetErr", 32'(bus.ERR), 32'd0);
    checkOutput("resetStart", 32'(bus.TX_START), 32'd0);
    checkOutput("resetData", 32'(bus.TX_DATA), 32'd0);
    rst_n     = 1'b1;
    ready_cyc = cyc + 1;
    repeat (3) nextCycle();
    checkOutput("idleNoReq", 32'(bus.GRANT), 32'd0);

    randomWords();
    words[0] = 8'hA5;
    applyStimulus(4'b0001, 1'b0, 1, 6);

    for (int n = 0; n < 5; n++) begin
      randomWords();
      applyStimulus(4'b1111, 1'b0, $urandom_range(0, 3), $urandom_range(2, 10));
    end

    randomWords();
    applyStimulus(4'b0100, 1'b1, 0, 0);

    randomWords();
    applyStimulus(4'b0010, 1'b0, 2, 5);
    randomWords();
    applyStimulus(4'b1000, 1'b0, 0, 4);

    applyResetMidFrame();
    randomWords();
    applyStimulus(4'b0011, 1'b0, 1, 3);

    for (int n = 0; n < 40; n++) begin
      randomWords();
      applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)), ($urandom_range(0, 4) == 0),
                    $urandom_range(0, TIMEOUT - 1), $urandom_range(1, 12));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares one serial transmitter among NREQ requesters.
- Round-robin arbitration; the granted word is captured and handed to the transmitter with a one-cycle start pulse.
- Tracks the transmitter busy flag through the frame, then acknowledges the requester.
- Sits between the requesting client logic (switch sampler, message sequencer) and the transmitter's Start/SWIn/TX_BUSY interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width; matches the transmitter's data width.
- GAP_CYCLES, 2, idle cycles forced between frames (0..15); TXD stays high during the gap.
- TIMEOUT, 15, max cycles to wait for TX_BUSY to rise after TX_START (1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester request level.
- DATA_IN  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- GRANT  out  NREQ  one-hot, high for the whole transaction.
- ACK  out  NREQ  one-cycle completion pulse to the granted requester.
- ERR  out  1  one-cycle pulse with ACK when the transaction timed out.
- TX_START  out  1  start pulse to the transmitter.
- TX_DATA  out  WIDTH  word to the transmitter's parallel input.
- TX_BUSY  in  1  transmitter busy flag.

Behaviour:
- Reset (async, RST_N=0) values: GRANT=0, ACK=0, ERR=0, TX_START=0, TX_DATA=0, state=IDLE, last pointer=NREQ-1, so requester 0 wins first. All outputs are registered.
- Requester rule: hold REQ high until ACK.
  - DATA_IN is sampled only in the grant cycle.
  - REQ dropped before grant: no effect.
  - REQ dropped after grant: the frame still completes and ACK is still pulsed. No abort.
- FSM states:
  - IDLE: if any REQ, select the winner by round-robin. The search starts at last+1 and wraps modulo NREQ. Set GRANT and TX_DATA<=word; last<=winner; go to START. With no REQ, stay in IDLE.
  - START: TX_START=1 for exactly this one cycle, TX_DATA stable. Clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY:
    - TX_BUSY=1: go to WAIT_DONE.
    - Else increment the counter. When the counter reaches TIMEOUT, pulse ACK[winner] and ERR, clear GRANT, and go to GAP.
  - WAIT_DONE: on TX_BUSY=0, pulse ACK[winner], clear GRANT, go to GAP. No timeout in this state.
  - GAP: count GAP_CYCLES, then go to IDLE. GAP_CYCLES=0 means GAP lasts 0 cycles and the FSM goes directly to IDLE.
- Latency:
  - REQ to TX_START: 2 cycles from REQ sampled high.
  - ACK is asserted 1 cycle after TX_BUSY is sampled low in WAIT_DONE.
- TX_DATA holds the last granted word until the next grant.
- REQ changes during a transaction affect only the next arbitration.
- A requester that keeps REQ high after ACK is re-arbitrated normally. It does not win twice in a row while others request.
- Illegal state encoding recovers to IDLE with outputs cleared (self-correction).
- Reset mid-frame: all outputs return to their reset values immediately. The transmitter finishes its frame independently, and the arbiter re-arbitrates from IDLE.
  - A frame already in flight is not acknowledged.
  - If a new transaction starts while TX_BUSY is still high, WAIT_BUSY sees it high at once. This is accepted, not an error.

Optional Feature:
- Macro TX_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The last pointer is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Single frame:
  - Stimulus: REQ=4'b0001, DATA_IN[7:0]=8'hA5, transmitter model attached.
  - Response: GRANT=0001 next cycle, then TX_START pulse with TX_DATA=A5, then one ACK[0] pulse after TX_BUSY falls. ERR stays 0.
- Round-robin:
  - Stimulus: REQ=4'b1111 held with distinct words, ACKs honoured and REQ kept high.
  - Response: grant order 0,1,2,3,0. Each TX_START is separated by at least frame length + GAP_CYCLES.
- Timeout:
  - Stimulus: TX_BUSY tied 0, REQ=4'b0100.
  - Response: ACK[2] and ERR pulse together 15 cycles after entering WAIT_BUSY, then GAP, then IDLE.
- Early drop:
  - Stimulus: REQ[1] deasserted one cycle after GRANT=0010.
  - Response: the frame is still sent and ACK[1] is still pulsed. A REQ[3] asserted meanwhile is served next.
- Reset mid-frame:
  - Stimulus: RST_N low during WAIT_DONE.
  - Response: GRANT/ACK/TX_START go to 0 asynchronously. After release with REQ=0001, requester 0 is granted first.
- Fixed priority build:
  - Stimulus: TX_ARBITER_FIXED_PRIO_EN defined, REQ=4'b1010 held.
  - Response: requester 1 is granted repeatedly and requester 3 is never granted while REQ[1]=1.
